// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: hex decode,
// brightness default and the width helper for the digit index.
package seg7_pkg;

   localparam logic [3:0] BRIGHT_FULL = 4'hF;

   // Active-low {dp,g,f,e,d,c,b,a}; dp is always off here and is applied by the caller.
   function automatic logic [7:0] hex2seg(input logic [3:0] nib);
      logic [7:0] pat;
      case (nib)
         4'h0: pat = 8'hC0;
         4'h1: pat = 8'hF9;
         4'h2: pat = 8'hA4;
         4'h3: pat = 8'hB0;
         4'h4: pat = 8'h99;
         4'h5: pat = 8'h92;
         4'h6: pat = 8'h82;
         4'h7: pat = 8'hF8;
         4'h8: pat = 8'h80;
         4'h9: pat = 8'h90;
         4'hA: pat = 8'h88;
         4'hB: pat = 8'h83;
         4'hC: pat = 8'hC6;
         4'hD: pat = 8'hA1;
         4'hE: pat = 8'h86;
         default: pat = 8'h8E;
      endcase
      return pat;
   endfunction

   // Never returns less than 1 so a single-digit build still has an index bit.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot counter and digit index for the scanner; exposes the brightness phase,
// the anti-ghost guard window and a slot-start marker.
module seg7_scan_timer
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_W     = 15,
   parameter int GUARD_CYC  = 64,
   parameter int IDX_W      = 3
) (
   input  logic             clk,
   input  logic             reset,
   output logic [IDX_W-1:0] idx_o,
   output logic [3:0]       phase_o,
   output logic             in_guard_o,
   output logic             slot_start_o
);

   localparam logic [SCAN_W-1:0] CNT_MAX  = '1;
   localparam logic [SCAN_W-1:0] GUARD_V  = SCAN_W'(GUARD_CYC);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [SCAN_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   always_comb begin
      cnt_d = cnt_q + SCAN_W'(1);
      idx_d = idx_q;
      // Explicit last-digit compare so non-power-of-2 digit counts wrap cleanly.
      if (cnt_q == CNT_MAX) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   assign idx_o        = idx_q;
   assign phase_o      = cnt_q[SCAN_W-1 -: 4];
   assign in_guard_o   = (cnt_q < GUARD_V);
   assign slot_start_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment controller: shadow registers, brightness PWM, blanking,
// decode and registered segment/select outputs. Define SEG7_LZS_EN for leading-zero suppression.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_W     = 15,
   parameter int GUARD_CYC  = 64,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cs,
   input  logic [4*NUM_DIGITS-1:0] iData,
   input  logic [NUM_DIGITS-1:0]   iDp,
   input  logic [NUM_DIGITS-1:0]   iBlank,
   input  logic [3:0]              iBright,
   output logic [7:0]              oSeg,
   output logic [NUM_DIGITS-1:0]   oSel
);

   localparam int IDX_W = clog2(NUM_DIGITS);
   localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [IDX_W-1:0] idx;
   logic [3:0]       phase;
   logic             in_guard, slot_start;

   seg7_scan_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_W     (SCAN_W),
      .GUARD_CYC  (GUARD_CYC),
      .IDX_W      (IDX_W)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .idx_o        (idx),
      .phase_o      (phase),
      .in_guard_o   (in_guard),
      .slot_start_o (slot_start)
   );

   logic [4*NUM_DIGITS-1:0] data_q, data_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d;
   logic [3:0]              bright_sh_q, bright_sh_d, bright_act_q, bright_act_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic [NUM_DIGITS-1:0]   supp;

`ifdef SEG7_LZS_EN
   logic zero_above;
   always_comb begin
      supp       = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above && (data_q[4*k +: 4] == 4'h0);
         supp[k]    = zero_above;
      end
   end
`else
   assign supp = '0;
`endif

   logic [3:0]            nib;
   logic [7:0]            pat;
   logic                  dp_on, lit;
   logic [NUM_DIGITS-1:0] sel_on;

   always_comb begin
      data_d       = cs ? iData   : data_q;
      dp_d         = cs ? iDp     : dp_q;
      blank_d      = cs ? iBlank  : blank_q;
      bright_sh_d  = cs ? iBright : bright_sh_q;
      // Active brightness only changes at a slot boundary so a slot never sees two duties.
      bright_act_d = slot_start ? bright_sh_q : bright_act_q;

      nib    = data_q[{idx, 2'b00} +: 4];
      dp_on  = dp_q[idx];
      pat    = supp[idx] ? 8'hFF : hex2seg(nib);
      if (dp_on) pat[7] = 1'b0;
      lit    = !in_guard && (phase <= bright_act_q) && !blank_q[idx] && (!supp[idx] || dp_on);
      sel_on = NUM_DIGITS'(1) << idx;

      seg_d = SEG_OFF;
      sel_d = SEL_OFF;
      if (lit) begin
         seg_d = (ACTIVE_LOW != 0) ? pat : ~pat;
         sel_d = (ACTIVE_LOW != 0) ? ~sel_on : sel_on;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q       <= '0;
         dp_q         <= '0;
         blank_q      <= '0;
         bright_sh_q  <= BRIGHT_FULL;
         bright_act_q <= BRIGHT_FULL;
         seg_q        <= SEG_OFF;
         sel_q        <= SEL_OFF;
      end else begin
         data_q       <= data_d;
         dp_q         <= dp_d;
         blank_q      <= blank_d;
         bright_sh_q  <= bright_sh_d;
         bright_act_q <= bright_act_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
      end
   end

   assign oSeg = seg_q;
   assign oSel = sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: an 8-digit active-low scanner and a 5-digit active-high
// scanner driven together and compared every cycle against a cycle-count based model.
module tb_seg7_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, cs;
   logic [31:0] iData_a;
   logic [7:0]  iDp_a, iBlank_a, oSeg_a, oSel_a;
   logic [19:0] iData_b;
   logic [4:0]  iDp_b, iBlank_b, oSel_b;
   logic [7:0]  oSeg_b;
   logic [3:0]  iBright;

   seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_W(6), .GUARD_CYC(2), .ACTIVE_LOW(1)) dut_a (
      .clk(clk), .reset(reset), .cs(cs), .iData(iData_a), .iDp(iDp_a), .iBlank(iBlank_a),
      .iBright(iBright), .oSeg(oSeg_a), .oSel(oSel_a));

   seg7_scan_ctrl #(.NUM_DIGITS(5), .SCAN_W(5), .GUARD_CYC(1), .ACTIVE_LOW(0)) dut_b (
      .clk(clk), .reset(reset), .cs(cs), .iData(iData_b), .iDp(iDp_b), .iBlank(iBlank_b),
      .iBright(iBright), .oSeg(oSeg_b), .oSel(oSel_b));

   int checks   = 0;
   int failures = 0;

   // Unit 0 = dut_a (64-cycle slots, 8 digits, guard 2); unit 1 = dut_b (32, 5, 1).
   function automatic int unit_s(input int u); return (u == 0) ? 64 : 32; endfunction
   function automatic int unit_n(input int u); return (u == 0) ? 8 : 5;   endfunction
   function automatic int unit_g(input int u); return (u == 0) ? 2 : 1;   endfunction

   function automatic logic [7:0] hexref(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
         4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
         4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
         4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   int          mn     [2];
   logic [31:0] mdata  [2];
   logic [7:0]  mdp    [2];
   logic [7:0]  mblank [2];
   logic [3:0]  mbsh   [2];
   logic [3:0]  mbact  [2];
   logic [7:0]  eseg   [2];
   logic [7:0]  esel   [2];
   bit          mvalid = 1'b0;
   logic [7:0]  ms, ml;

   // Expected outputs for the cycle count mn[u] since reset release.
   function automatic void model_out(input int u, output logic [7:0] seg, output logic [7:0] sel);
      int s, nd, c, d, ph;
      logic [7:0] mask;
      bit lit;
      s    = unit_s(u);
      nd   = unit_n(u);
      c    = mn[u] % s;
      d    = (mn[u] / s) % nd;
      ph   = c / (s / 16);
      mask = 8'((1 << nd) - 1);
      lit  = (c >= unit_g(u)) && (ph <= int'(mbact[u])) && !mblank[u][d];
      seg  = hexref(4'((mdata[u] >> (4 * d)) & 32'hF));
      if (mdp[u][d]) seg[7] = 1'b0;
`ifdef SEG7_LZS_EN
      if (d > 0 && (mdata[u] >> (4 * d)) == 32'h0) begin
         seg = mdp[u][d] ? 8'h7F : 8'hFF;
         if (!mdp[u][d]) lit = 1'b0;
      end
`endif
      if (!lit) begin
         seg = 8'hFF;
         sel = mask;
      end else begin
         sel = mask & ~8'(1 << d);
      end
      if (u == 1) begin
         seg = ~seg;
         sel = ~sel & mask;
      end
   endfunction

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (reset) begin
            mn[u] = 0; mdata[u] = '0; mdp[u] = '0; mblank[u] = '0;
            mbsh[u] = 4'hF; mbact[u] = 4'hF;
            eseg[u] = (u == 0) ? 8'hFF : 8'h00;
            esel[u] = (u == 0) ? 8'hFF : 8'h00;
         end else begin
            model_out(u, ms, ml);
            eseg[u] = ms;
            esel[u] = ml;
            if (mn[u] % unit_s(u) == 0) mbact[u] = mbsh[u];
            if (cs) begin
               mdata[u]  = (u == 0) ? iData_a : {12'h0, iData_b};
               mdp[u]    = (u == 0) ? iDp_a : {3'b0, iDp_b};
               mblank[u] = (u == 0) ? iBlank_a : {3'b0, iBlank_b};
               mbsh[u]   = iBright;
            end
            mn[u]++;
         end
      end
      if (reset) mvalid = 1'b1;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (mvalid) begin
         chk("scan_a_seg", {8'h0, oSeg_a}, {8'h0, eseg[0]});
         chk("scan_a_sel", {8'h0, oSel_a}, {8'h0, esel[0]});
         chk("scan_b_seg", {8'h0, oSeg_b}, {8'h0, eseg[1]});
         chk("scan_b_sel", {11'h0, oSel_b}, {8'h0, esel[1]});
      end
   endtask

   // Advance until the outputs of unit u reflect slot position c; returns that slot's digit.
   task automatic wait_pos(input int u, input int c, output int d);
      int s;
      s = unit_s(u);
      d = -1;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (mn[u] > 0 && (mn[u] - 1) % s == c) begin
            d = ((mn[u] - 1) / s) % unit_n(u);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL wait_pos unit=%0d pos=%0d not reached within budget", u, c);
   endtask

   task automatic wr(input logic [31:0] dat, input logic [7:0] dp, input logic [7:0] bl,
                     input logic [3:0] br);
      cs = 1'b1; iData_a = dat; iData_b = dat[19:0]; iDp_a = dp; iDp_b = dp[4:0];
      iBlank_a = bl; iBlank_b = bl[4:0]; iBright = br;
      tick();
      cs = 1'b0;
   endtask

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic [3:0]  br;
      int          dig;
      logic [7:0]  seg;
      logic [7:0]  sel;
   } vec_t;

   vec_t tbl[13];
   int   d, d2, k0;
   logic [31:0] rd;

   initial begin
      tbl[0]  = '{32'h89ABCDEF, 8'h01, 8'h00, 4'hF, 0, 8'h0E, 8'hFE};
      tbl[1]  = '{32'h89ABCDEF, 8'h01, 8'h00, 4'hF, 7, 8'h80, 8'h7F};
      tbl[2]  = '{32'h89ABCDEF, 8'h01, 8'h00, 4'hF, 3, 8'hC6, 8'hF7};
`ifdef SEG7_LZS_EN
      tbl[3]  = '{32'h00000120, 8'h00, 8'h00, 4'hF, 3, 8'hFF, 8'hFF};
      tbl[10] = '{32'h00000000, 8'h08, 8'h00, 4'hF, 3, 8'h7F, 8'hF7};
      tbl[11] = '{32'h00000000, 8'h00, 8'h00, 4'hF, 5, 8'hFF, 8'hFF};
`else
      tbl[3]  = '{32'h00000120, 8'h00, 8'h00, 4'hF, 3, 8'hC0, 8'hF7};
      tbl[10] = '{32'h00000000, 8'h08, 8'h00, 4'hF, 3, 8'h40, 8'hF7};
      tbl[11] = '{32'h00000000, 8'h00, 8'h00, 4'hF, 5, 8'hC0, 8'hDF};
`endif
      tbl[4]  = '{32'h00000120, 8'h00, 8'h00, 4'hF, 1, 8'hA4, 8'hFD};
      tbl[5]  = '{32'h00000120, 8'h00, 8'h00, 4'hF, 2, 8'hF9, 8'hFB};
      tbl[6]  = '{32'h12345678, 8'h80, 8'h00, 4'hF, 7, 8'h79, 8'h7F};
      tbl[7]  = '{32'h12345678, 8'h00, 8'h04, 4'hF, 2, 8'hFF, 8'hFF};
      tbl[8]  = '{32'h12345678, 8'h00, 8'h04, 4'hF, 3, 8'h92, 8'hF7};
      tbl[9]  = '{32'h00000000, 8'h00, 8'h00, 4'hF, 0, 8'hC0, 8'hFE};
      tbl[12] = '{32'h00000007, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 8'hFF};

      // Reset held with cs active and all-ones data: nothing may be captured.
      reset = 1'b1; cs = 1'b1; iData_a = 32'hFFFFFFFF; iData_b = 20'hFFFFF;
      iDp_a = 8'hFF; iDp_b = 5'h1F; iBlank_a = 8'h00; iBlank_b = 5'h00; iBright = 4'h0;
      repeat (4) tick();
      reset = 1'b0; cs = 1'b0;
      tick();
      chk("rst_sel_a", {8'h0, oSel_a}, 16'h00FF);
      chk("rst_seg_a", {8'h0, oSeg_a}, 16'h00FF);
      chk("rst_sel_b", {11'h0, oSel_b}, 16'h0000);
      chk("rst_seg_b", {8'h0, oSeg_b}, 16'h0000);
      wait_pos(0, 60, d);
      chk("rst_digit", d[15:0], 16'd0);
      chk("rst_data_seg", {8'h0, oSeg_a}, 16'h00C0);
      chk("rst_bright_sel", {8'h0, oSel_a}, 16'h00FE);

      // Five-digit active-high scanner: guard at slot start, then digits in order with wrap.
      wait_pos(1, 16, k0);
      for (int k = 1; k <= 6; k++) begin
         wait_pos(1, 0, d);
         chk("b_guard_sel", {11'h0, oSel_b}, 16'h0000);
         wait_pos(1, 16, d);
         chk("b_idx_sel", {11'h0, oSel_b}, 16'(1 << ((k0 + k) % 5)));
      end

      for (int i = 0; i < 13; i++) begin
         wr(tbl[i].data, tbl[i].dp, tbl[i].blank, tbl[i].br);
         wait_pos(0, 0, d);
         for (int j = 0; j < 9; j++) begin
            wait_pos(0, 32, d);
            if (d == tbl[i].dig) break;
         end
         chk($sformatf("vec%0d_seg", i), {8'h0, oSeg_a}, {8'h0, tbl[i].seg});
         chk($sformatf("vec%0d_sel", i), {8'h0, oSel_a}, {8'h0, tbl[i].sel});
      end

      // Brightness drop written mid-slot takes effect only from the next slot.
      wr(32'h12345678, 8'h00, 8'h00, 4'hF);
      wait_pos(0, 0, d);
      wait_pos(0, 16, d);
      wr(32'h12345678, 8'h00, 8'h00, 4'h0);
      wait_pos(0, 60, d);
      chk("br_old_duty", {8'h0, oSel_a}, {8'h0, ~8'(1 << d)});
      wait_pos(0, 1, d2);
      chk("br_guard", {8'h0, oSel_a}, 16'h00FF);
      wait_pos(0, 3, d2);
      chk("br_phase0", {8'h0, oSel_a}, {8'h0, ~8'(1 << d2)});
      wait_pos(0, 4, d2);
      chk("br_phase1", {8'h0, oSel_a}, 16'h00FF);

      // Reset in the middle of a lit window blanks the outputs on that edge.
      wr(32'h12345678, 8'h00, 8'h00, 4'hF);
      wait_pos(0, 0, d);
      wait_pos(0, 32, d);
      chk("midrst_pre", {8'h0, oSel_a}, {8'h0, ~8'(1 << d)});
      reset = 1'b1;
      tick();
      chk("midrst_sel_a", {8'h0, oSel_a}, 16'h00FF);
      chk("midrst_seg_a", {8'h0, oSeg_a}, 16'h00FF);
      chk("midrst_sel_b", {11'h0, oSel_b}, 16'h0000);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rd = $urandom;
            if ($urandom_range(0, 2) == 0) rd = rd >> (4 * $urandom_range(0, 8));
            wr(rd, 8'($urandom), 8'($urandom & $urandom & $urandom), 4'($urandom));
         end else if ($urandom_range(0, 799) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            tick();
         end else begin
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
